seg_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller for an NDIGIT seven-segment display bank on the GPIO peripheral.

---
 rtl/seg_scan_ctrl_if.sv | 11 +
 rtl/seg_scan_ctrl.sv | 122 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// Write port of the seven-segment scan controller: value and digit-mask writes.
// The CPU side (master) drives it. The scan controller (slave) samples it on every clock.
interface seg_scan_ctrl_if;
    logic        val_wr;
    logic [3:0]  val_strb;
    logic [31:0] wr_data;
    logic        mask_wr;

    modport master (output val_wr, val_strb, wr_data, mask_wr);
    modport slave  (input  val_wr, val_strb, wr_data, mask_wr);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller.
// Steps through NDIGIT digits and keeps each one selected for DIV cycles.
// For the selected digit it drives the nibble and enable to a shared hex decoder,
// together with an active-low one-hot digit select.
// CPU writes land in value/mask registers. They are copied into shadow registers
// only at frame wrap, and in the first cycle after reset, so a frame never tears.
// Optional build macro SEG_SCAN_LZ_BLANK_EN: blanks leading zero digits, except digit 0.
module seg_scan_ctrl #(
    parameter int NDIGIT = 8,
    parameter int DIV    = 1000,
    parameter int DIV_W  = $clog2(DIV)
) (
    input  logic              clock_i,
    input  logic              reset_i,
    seg_scan_ctrl_if.slave    wr_if,
    output logic [3:0]        bcd_o,
    output logic              en_o,
    output logic [NDIGIT-1:0] digit_sel_o,
    output logic              frame_start_o
);
    localparam int IDX_W = (NDIGIT > 1) ? $clog2(NDIGIT) : 1;
    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIGIT - 1);

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       value_q, value_d;
    logic [NDIGIT-1:0] mask_q, mask_d;
    logic [31:0]       shadow_val_q, shadow_val_d;
    logic [NDIGIT-1:0] shadow_mask_q, shadow_mask_d;
    logic              first_q;
    logic              wrap_q, wrap_d;
    logic [3:0]        bcd_q, bcd_d;
    logic              en_q, en_d;
    logic [NDIGIT-1:0] sel_q, sel_d;
    logic              fs_q, fs_d;
    logic              tick;
    logic [NDIGIT-1:0] lz_blank;
`ifdef SEG_SCAN_LZ_BLANK_EN
    logic              lz_seen;
`endif

    assign tick = (cnt_q == CNT_LAST);

    // State register: sync reset aborts the scan and clears everything.
    // first_q is left set by reset so that the shadows load on the first cycle out of reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            value_q       <= '0;
            mask_q        <= '0;
            shadow_val_q  <= '0;
            shadow_mask_q <= '0;
            first_q       <= 1'b1;
            wrap_q        <= 1'b0;
            bcd_q         <= '0;
            en_q          <= 1'b0;
            sel_q         <= '1;
            fs_q          <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            value_q       <= value_d;
            mask_q        <= mask_d;
            shadow_val_q  <= shadow_val_d;
            shadow_mask_q <= shadow_mask_d;
            first_q       <= 1'b0;
            wrap_q        <= wrap_d;
            bcd_q         <= bcd_d;
            en_q          <= en_d;
            sel_q         <= sel_d;
            fs_q          <= fs_d;
        end
    end

    // Next state: prescaler, digit index, byte-masked writes, and the shadow load.
    // The shadow load takes the merged value, so a write on the wrap cycle is not lost.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        value_d = value_q;
        for (int k = 0; k < 4; k++) begin
            if (wr_if.val_wr && wr_if.val_strb[k]) begin
                value_d[8*k +: 8] = wr_if.wr_data[8*k +: 8];
            end
        end
        mask_d        = wr_if.mask_wr ? wr_if.wr_data[NDIGIT-1:0] : mask_q;
        wrap_d        = tick && (idx_q == IDX_LAST);
        shadow_val_d  = shadow_val_q;
        shadow_mask_d = shadow_mask_q;
        if (wrap_d || first_q) begin
            shadow_val_d  = value_d;
            shadow_mask_d = mask_d;
        end
    end

    // Output decode: registered outputs follow idx one cycle later.
    // frame_start fires in the cycle when digit 0 comes back.
    always_comb begin
        lz_blank = '0;
`ifdef SEG_SCAN_LZ_BLANK_EN
        lz_seen = 1'b0;
        for (int i = NDIGIT - 1; i >= 1; i--) begin
            lz_seen     = lz_seen | (shadow_val_q[4*i +: 4] != 4'h0);
            lz_blank[i] = ~lz_seen;
        end
`endif
        bcd_d = shadow_val_q[4*idx_q +: 4];
        en_d  = shadow_mask_q[idx_q] & ~lz_blank[idx_q];
        sel_d = ~(NDIGIT'(1) << idx_q);
        fs_d  = first_q | wrap_q;
    end

    assign bcd_o         = bcd_q;
    assign en_o          = en_q;
    assign digit_sel_o   = sel_q;
    assign frame_start_o = fs_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl with NDIGIT=8 and DIV=4.
// A reference model predicts the outputs every cycle from the elapsed cycle count since reset.
// Directed vectors and hand sequences cover the multi-cycle corner cases.
module tb_seg_scan_ctrl;
    localparam int NDIGIT = 8;
    localparam int DIV    = 4;
    localparam int FRAME  = NDIGIT * DIV;
`ifdef SEG_SCAN_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    typedef struct {
        logic        vw;
        logic [3:0]  strb;
        logic [31:0] data;
        logic        mw;
        logic [31:0] exp_val;
        logic [7:0]  exp_en;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] bcd;
    logic       en;
    logic [7:0] sel;
    logic       fs;
    int         checks = 0;
    int         errors = 0;

    logic [31:0] m_val = '0, s_val = '0;
    logic [7:0]  m_mask = '0, s_mask = '0;
    int          k = 0;

    seg_scan_ctrl_if bus();

    seg_scan_ctrl #(.NDIGIT(NDIGIT), .DIV(DIV)) dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .wr_if         (bus),
        .bcd_o         (bcd),
        .en_o          (en),
        .digit_sel_o   (sel),
        .frame_start_o (fs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic vw, input logic [3:0] st, input logic [31:0] dt, input logic mw);
        bus.val_wr   = vw;
        bus.val_strb = st;
        bus.wr_data  = dt;
        bus.mask_wr  = mw;
        tick();
        bus.val_wr   = 1'b0;
        bus.val_strb = 4'h0;
        bus.mask_wr  = 1'b0;
    endtask

    // Step until the next edge is the one with the given frame phase.
    task automatic align(input int ph, input string name);
        int n = 0;
        while ((k % FRAME) != ph && n < 2 * FRAME) begin
            tick();
            n++;
        end
        checks++;
        if ((k % FRAME) != ph) begin
            errors++;
            $display("FAIL %s phase=%0d required=%0d", name, k % FRAME, ph);
        end
    endtask

    task automatic wait_fs(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!fs && n < 2 * FRAME);
        chk(name, fs, 1);
    endtask

    // Digit dg is a leading zero if dg > 0 and every nibble from dg upward is zero.
    function automatic bit lz_hidden(input logic [31:0] v, input int dg);
        return LZ && (dg > 0) && ((v >> (4 * dg)) == 32'h0);
    endfunction

    // Reference model, driven by k = number of edges since reset was released.
    // Digit shown = (k/DIV) % NDIGIT. frame_start is expected when k is a multiple of FRAME.
    // The shadow reloads at k==0 and on each frame's last edge, after that edge's writes are applied.
    always @(posedge clk) begin : model
        logic        r_s, vw_s, mw_s;
        logic [3:0]  st_s;
        logic [31:0] d_s;
        int          d;
        logic [3:0]  e_bcd;
        logic        e_en, e_fs;
        logic [7:0]  e_sel;
        r_s  = rst;
        vw_s = bus.val_wr;
        mw_s = bus.mask_wr;
        st_s = bus.val_strb;
        d_s  = bus.wr_data;
        #1;
        if (r_s) begin
            e_bcd = 4'h0; e_en = 1'b0; e_sel = 8'hFF; e_fs = 1'b0;
            m_val = '0; m_mask = '0; s_val = '0; s_mask = '0; k = 0;
        end else begin
            d     = (k / DIV) % NDIGIT;
            e_bcd = s_val[4*d +: 4];
            e_en  = s_mask[d] && !lz_hidden(s_val, d);
            e_sel = ~(8'(1) << d);
            e_fs  = (k % FRAME) == 0;
            for (int b = 0; b < 4; b++)
                if (vw_s && st_s[b]) m_val[8*b +: 8] = d_s[8*b +: 8];
            if (mw_s) m_mask = d_s[7:0];
            if (k == 0 || (k % FRAME) == FRAME - 1) begin
                s_val  = m_val;
                s_mask = m_mask;
            end
            k++;
        end
        chk("model_bcd", bcd, e_bcd);
        chk("model_en", en, e_en);
        chk("model_sel", sel, e_sel);
        chk("model_fs", fs, e_fs);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        int   n;
        tbl[0] = '{1'b0, 4'h0, 32'h0000_00FF, 1'b1, 32'h0000_0000, LZ ? 8'h01 : 8'hFF};
        tbl[1] = '{1'b1, 4'hF, 32'h89AB_CDEF, 1'b0, 32'h89AB_CDEF, 8'hFF};
        tbl[2] = '{1'b1, 4'h1, 32'h0000_0012, 1'b0, 32'h89AB_CD12, 8'hFF};
        tbl[3] = '{1'b1, 4'hC, 32'h5566_0000, 1'b0, 32'h5566_CD12, 8'hFF};
        tbl[4] = '{1'b0, 4'h0, 32'h0000_000F, 1'b1, 32'h5566_CD12, 8'h0F};
        tbl[5] = '{1'b0, 4'h0, 32'h0000_00FF, 1'b1, 32'h5566_CD12, 8'hFF};
        tbl[6] = '{1'b1, 4'hF, 32'h0000_0300, 1'b0, 32'h0000_0300, LZ ? 8'h07 : 8'hFF};
        tbl[7] = '{1'b1, 4'hF, 32'h0000_0000, 1'b0, 32'h0000_0000, LZ ? 8'h01 : 8'hFF};
        tbl[8] = '{1'b1, 4'h3, 32'h0000_00A5, 1'b1, 32'h0000_00A5, LZ ? 8'h01 : 8'hA5};

        bus.val_wr = 1'b0; bus.val_strb = 4'h0; bus.wr_data = '0; bus.mask_wr = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset release: digit 0 selected at once, 4-cycle dwell, 32-cycle frame.
        tick();
        chk("t1_sel_first", sel, 8'hFE);
        chk("t1_en_first", en, 1'b0);
        chk("t1_fs_first", fs, 1'b1);
        repeat (4) tick();
        chk("t1_sel_second", sel, 8'hFD);
        chk("t1_fs_second", fs, 1'b0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!fs && n < 64);
        chk("t1_fs_gap", n, 28);

        // Directed vectors: write, then check one full frame of the following display.
        for (int i = 0; i < 9; i++) begin
            wr(tbl[i].vw, tbl[i].strb, tbl[i].data, tbl[i].mw);
            wait_fs($sformatf("v%0d_fs", i));
            for (int c = 0; c < FRAME; c++) begin
                chk($sformatf("v%0d_bcd_d%0d", i, c / DIV), bcd, tbl[i].exp_val[4*(c/DIV) +: 4]);
                chk($sformatf("v%0d_en_d%0d", i, c / DIV), en, tbl[i].exp_en[c/DIV]);
                tick();
            end
        end

        // Mid-frame write at digit 3: current frame unchanged, next frame updated.
        wr(1'b1, 4'hF, 32'h89AB_CDEF, 1'b0);
        wr(1'b0, 4'h0, 32'h0000_00FF, 1'b1);
        align(0, "t3_align0");
        align(13, "t3_align13");
        wr(1'b1, 4'h1, 32'h0000_0012, 1'b0);
        chk("t3_cur_bcd3", bcd, 4'hC);
        wait_fs("t3_fs");
        chk("t3_next_d0", bcd, 4'h2);
        repeat (4) tick();
        chk("t3_next_d1", bcd, 4'h1);
        repeat (4) tick();
        chk("t3_next_d2", bcd, 4'hD);

        // Write on the exact frame-wrap edge is shown in the very next frame.
        align(FRAME - 1, "t4_align");
        wr(1'b1, 4'hF, 32'hCAFE_1234, 1'b0);
        tick();
        chk("t4_fs", fs, 1'b1);
        chk("t4_bcd0", bcd, 4'h4);
        chk("t4_en0", en, 1'b1);
        repeat (4) tick();
        chk("t4_bcd1", bcd, 4'h3);

        // Reset while digit 5 is shown.
        align(22, "t5_align");
        rst = 1'b1;
        tick();
        chk("t5_sel_rst", sel, 8'hFF);
        chk("t5_en_rst", en, 1'b0);
        chk("t5_bcd_rst", bcd, 4'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("t5_sel_restart", sel, 8'hFE);
        chk("t5_bcd_restart", bcd, 4'h0);
        chk("t5_fs_restart", fs, 1'b1);
        repeat (4) tick();
        chk("t5_sel_d1", sel, 8'hFD);
        chk("t5_en_d1", en, 1'b0);

        // Random traffic against the model, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 399) == 0);
            bus.val_wr   = ($urandom_range(0, 5) == 0);
            bus.val_strb = 4'($urandom);
            bus.wr_data  = $urandom >> $urandom_range(0, 31);
            bus.mask_wr  = ($urandom_range(0, 15) == 0);
            tick();
        end
        rst = 1'b0; bus.val_wr = 1'b0; bus.mask_wr = 1'b0;
        repeat (FRAME) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
